// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, bus constants and the open-drain drive table
// used by the single-byte I2C write master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP,
        DONE
    } state_t;

    localparam logic I2C_WRITE = 1'b0;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BITS_PER_BYTE = 8;
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    // Returns {scl_oe, sda_oe} for a quarter of a slot; b is the data bit
    // being shifted out (only meaningful in ADDR/DATA slots).
    function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] q, input logic b);
        logic [1:0] d;
        d = 2'b00;
        case (s)
            START: begin
                case (q)
                    Q0, Q1:  d = 2'b00;
                    Q2:      d = 2'b01;
                    default: d = 2'b11;
                endcase
            end
            ADDR, DATA: d = {(q == Q0) || (q == Q3), ~b};
            ACK1, ACK2: d = {(q == Q0) || (q == Q3), 1'b0};
            STOP: begin
                case (q)
                    Q0:      d = 2'b11;
                    Q1, Q2:  d = 2'b01;
                    default: d = 2'b00;
                endcase
            end
            default: d = 2'b00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: divides the system clock into SCL quarter periods and
// tracks which quarter (Q0..Q3) of the current bit slot is active.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       clear,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] count;

    assign tick = !clear && (count == LAST);

    // Count system clocks within a quarter and advance the quarter index on each tick.
    always_ff @(posedge clk) begin
        if (clear) begin
            count   <= 8'd0;
            quarter <= Q0;
        end else if (tick) begin
            count   <= 8'd0;
            quarter <= quarter + 2'd1;
        end else begin
            count   <= count + 8'd1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// i2c_write_master: issues START, address+W, data byte and STOP on an
// open-drain I2C bus, checking both ACK slots and reporting completion.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk1,
    input  logic       reset1,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_t     state;
    logic [7:0] shreg;
    logic [7:0] data_lat;
    logic [2:0] bit_cnt;
    logic       nack;
    logic       tick;
    logic [1:0] quarter;
    logic       tick_clear;

    // The quarter timer only runs while a transfer is in flight so every
    // transfer starts at the beginning of Q0.
    assign tick_clear = reset1 || (state == IDLE) || (state == DONE);

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk1),
        .clear  (tick_clear),
        .tick   (tick),
        .quarter(quarter)
    );

    // Transfer sequencer: on each quarter tick the line drive for the next
    // quarter is registered, and slot boundaries advance the state.
    always_ff @(posedge clk1) begin
        if (reset1) begin
            state    <= IDLE;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            shreg    <= 8'd0;
            data_lat <= 8'd0;
            bit_cnt  <= 3'd0;
            nack     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state              <= START;
                        shreg              <= {addr, I2C_WRITE};
                        data_lat           <= data;
                        bit_cnt            <= 3'd0;
                        nack               <= 1'b0;
                        ack_err            <= 1'b0;
                        busy               <= 1'b1;
                        {scl_oe, sda_oe}   <= line_drive(START, Q0, 1'b1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    if (tick) begin
                        if (quarter != Q3) begin
                            if (((state == ACK1) || (state == ACK2)) && (quarter == Q2)) begin
                                nack <= sda_in;
                                if (sda_in) begin
                                    ack_err <= 1'b1;
                                end
                            end
                            {scl_oe, sda_oe} <= line_drive(state, quarter + 2'd1, shreg[7]);
                        end else begin
                            case (state)
                                START: begin
                                    state            <= ADDR;
                                    {scl_oe, sda_oe} <= line_drive(ADDR, Q0, shreg[7]);
                                end
                                ADDR, DATA: begin
                                    if (bit_cnt == LAST_BIT) begin
                                        state            <= (state == ADDR) ? ACK1 : ACK2;
                                        {scl_oe, sda_oe} <= line_drive(ACK1, Q0, 1'b1);
                                    end else begin
                                        bit_cnt          <= bit_cnt + 3'd1;
                                        shreg            <= {shreg[6:0], 1'b0};
                                        {scl_oe, sda_oe} <= line_drive(state, Q0, shreg[6]);
                                    end
                                end
                                ACK1: begin
                                    if (nack) begin
                                        state            <= STOP;
                                        {scl_oe, sda_oe} <= line_drive(STOP, Q0, 1'b1);
                                    end else begin
                                        state            <= DATA;
                                        shreg            <= data_lat;
                                        bit_cnt          <= 3'd0;
                                        {scl_oe, sda_oe} <= line_drive(DATA, Q0, data_lat[7]);
                                    end
                                end
                                ACK2: begin
                                    state            <= STOP;
                                    {scl_oe, sda_oe} <= line_drive(STOP, Q0, 1'b1);
                                end
                                STOP: begin
                                    state            <= DONE;
                                    {scl_oe, sda_oe} <= 2'b00;
                                    busy             <= 1'b0;
                                    done             <= 1'b1;
                                end
                                default: begin
                                    state <= IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_write_master.md
# i2c_write_master

Single-byte I²C write controller (bus initiator) that produces SCL/SDA for the serial link consumed by the existing receive side of the project. A one-cycle `start` launches START, address+W, ACK check, one data byte, ACK check, STOP. Lines are open-drain via output-enable bits; the top level turns them into tri-state pads. No clock stretching, no repeated START, no multi-master arbitration.

## Interface
- `CLK_DIV`, default 4: system clocks per SCL quarter-period; legal range 1..255.
- `clk1` input 1: system clock; all logic on the rising edge.
- `reset1` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `addr` input 7: target address; latched when `start` is accepted.
- `data` input 8: write byte; latched when `start` is accepted. The top level feeds it as {5'b0, datain[2:0]}.
- `sda_in` input 1: resolved SDA level, already synchronised by the top level.
- `scl_oe` output 1: 1 = pull SCL low; 0 = release SCL high.
- `sda_oe` output 1: 1 = pull SDA low; 0 = release SDA high.
- `busy` output 1: high from the cycle after acceptance until the done cycle.
- `done` output 1: one-cycle pulse when the transfer finishes.
- `ack_err` output 1: set if any ACK slot read 1; holds until the next accepted `start`.

## Operation
- Reset and IDLE outputs: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0. Reset also forces `ack_err`=0.
- Quarter tick: a counter runs 0..CLK_DIV-1 and ticks on CLK_DIV-1. Each bit slot is quarters Q0..Q3.
- Data slot: Q0 holds SCL low and sets SDA. Q1–Q2 release SCL. Q3 holds SCL low. SDA changes only at the start of Q0.
- States and transitions:
  - IDLE: when `start`=1, latch `addr`/`data`, clear `ack_err`, go to START. The counter and quarter index are zeroed.
  - START (1 slot): Q0–Q1 release both lines; Q2 drives SDA low with SCL released (the START condition); Q3 drives both low. Then ADDR.
  - ADDR (8 slots): shifts {addr, 1'b0} MSB first. Then ACK1.
  - ACK1 (1 slot): SDA released; sample `sda_in` on the tick ending Q2. If 1, set `ack_err` and go to STOP; if 0, go to DATA.
  - DATA (8 slots): shifts `data` MSB first. Then ACK2.
  - ACK2 (1 slot): same as ACK1, but always goes to STOP.
  - STOP (1 slot): Q0 drives both low; Q1–Q2 drive SDA low with SCL released; Q3 releases both (the STOP condition). Then DONE.
  - DONE (1 cycle): `done`=1, `busy`=0, lines released, then IDLE.
- `start` while not in IDLE is ignored. `start` in the DONE cycle is ignored.
- Reset mid-transfer: IDLE on the next edge with both lines released. No STOP is generated.

## Timing
- Acceptance edge = cycle N. `busy`=1 from N+1.
- Full transfer: 80 quarters (START 4, ADDR 32, ACK1 4, DATA 32, ACK2 4, STOP 4). `done`=1 at cycle N+1+80·CLK_DIV, with `busy` falling in the same cycle.
- Address NACK: 44 quarters. `done` at N+1+44·CLK_DIV.
- SCL period = 4·CLK_DIV clocks. SDA is stable for the entire SCL-high window.
- Earliest next acceptance: the cycle after DONE.

## Structure
- Package `i2c_pkg` holds:
  - the state enum (IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE);
  - `I2C_WRITE` = 1'b0;
  - the quarter indices Q0..Q3;
  - bits-per-byte = 8.
- Sub-module `i2c_quarter_tick`: parameterised by CLK_DIV, with a synchronous clear. Outputs a one-cycle `tick` plus a 2-bit quarter index.
- The FSM, 3-bit bit counter and shift register live in the top module.

## Test plan
All cases use CLK_DIV=4, `addr`=7'h2A, `data`=8'h05.
1. Reset held for 3 cycles with `start`=1 -> `scl_oe`=`sda_oe`=`busy`=`done`=`ack_err`=0 throughout; no transfer begins.
2. `start` pulse, responder drives ACK=0 in both slots -> decoded bytes on SCL rising edges are 0x54 then 0x05. START and STOP conditions are present. `done` arrives 321 cycles after acceptance and `ack_err`=0.
3. `sda_in`=1 during ACK1 -> no DATA slots; STOP follows. `done` arrives 177 cycles after acceptance and `ack_err`=1.
4. ACK1=0, ACK2=1 -> all 18 slots run. `ack_err`=1 at `done`, and is cleared on the next accepted `start`.
5. `start` re-pulsed at cycles 40 and 321 after acceptance -> both ignored; only one transfer occurs.
6. `reset1` asserted at cycle 100 of a transfer -> next edge: both lines released, `busy`=0, no `done` pulse. A new `start` afterwards completes normally.
